// File: rtl/debouncer_array.sv
// Per-channel button debouncer: 2-flop synchroniser, stable-count filter, press/release
// edge pulses and an optional long-press / auto-repeat hold pulse.
module debouncer_array #(
   parameter int unsigned          CHANNELS        = 4,
   parameter int unsigned          DEBOUNCE_CYCLES = 1000,
   parameter logic [CHANNELS-1:0]  INPUT_WHEN_IDLE = '1,
   parameter int unsigned          HOLD_CYCLES     = 0,
   parameter int unsigned          REPEAT_CYCLES   = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] active,
   output logic [CHANNELS-1:0] press,
   // "release" is a reserved word in SystemVerilog, hence the suffix
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] hold
);

   localparam int unsigned DW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HMAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned HW    = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
   localparam int unsigned DLAST = DEBOUNCE_CYCLES - 1;
   localparam int unsigned HLAST = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
   localparam int unsigned RLAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic          sync1, sync2;
      logic          out_q, active_q, press_q, release_q, hold_q;
      logic          fired;
      logic [DW-1:0] dcnt;
      logic [HW-1:0] hcnt;
      logic          differ_c, flip_c;

      assign differ_c = (sync2 != out_q);
      assign flip_c   = differ_c && (dcnt == DW'(DLAST));

      // Debounce filter plus hold timer; the hold timer only runs while active and not flipping.
      always_ff @(posedge clk) begin
         if (rst) begin
            sync1     <= INPUT_WHEN_IDLE[i];
            sync2     <= INPUT_WHEN_IDLE[i];
            out_q     <= INPUT_WHEN_IDLE[i];
            active_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
            fired     <= 1'b0;
            dcnt      <= '0;
            hcnt      <= '0;
         end else begin
            sync1     <= in[i];
            sync2     <= sync1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;

            if (!differ_c || flip_c) dcnt <= '0;
            else                     dcnt <= dcnt + DW'(1);

            if (flip_c) begin
               out_q     <= sync2;
               active_q  <= (sync2 != INPUT_WHEN_IDLE[i]);
               press_q   <= (sync2 != INPUT_WHEN_IDLE[i]);
               release_q <= (sync2 == INPUT_WHEN_IDLE[i]);
               hcnt      <= '0;
               fired     <= 1'b0;
            end else if (active_q && (HOLD_CYCLES > 0)) begin
               if (!fired) begin
                  if (hcnt == HW'(HLAST)) begin
                     hold_q <= 1'b1;
                     fired  <= 1'b1;
                     // single-shot mode parks the counter at its terminal value
                     hcnt   <= (REPEAT_CYCLES > 0) ? '0 : hcnt;
                  end else begin
                     hcnt <= hcnt + HW'(1);
                  end
               end else if (REPEAT_CYCLES > 0) begin
                  if (hcnt == HW'(RLAST)) begin
                     hold_q <= 1'b1;
                     hcnt   <= '0;
                  end else begin
                     hcnt <= hcnt + HW'(1);
                  end
               end
            end
         end
      end

      assign out[i]           = out_q;
      assign active[i]        = active_q;
      assign press[i]         = press_q;
      assign release_pulse[i] = release_q;
      assign hold[i]          = hold_q;
   end

endmodule

// File: tb/tb_debouncer_array.sv
// Directed + randomized bench for debouncer_array against a cycle-level behavioural model.
module tb_debouncer_array;

   localparam int unsigned CH  = 2;
   localparam int unsigned DEB = 4;
   localparam int unsigned HLD = 10;
   localparam int unsigned REP = 5;
   localparam logic [1:0]  IDLE = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] din;
   logic [1:0] dout, dact, dpress, drel, dhold;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // behavioural model state
   logic [1:0] m_s1, m_s2, m_out, m_press, m_rel, m_hold;
   int m_run  [2];
   int m_pcyc [2];
   int press_seen [2] = '{0, 0};
   int rel_seen   [2] = '{0, 0};
   int hold_seen  [2] = '{0, 0};

   always #5 clk = ~clk;

   debouncer_array #(
      .CHANNELS(CH), .DEBOUNCE_CYCLES(DEB), .INPUT_WHEN_IDLE(IDLE),
      .HOLD_CYCLES(HLD), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rst(rst), .in(din), .out(dout), .active(dact),
      .press(dpress), .release_pulse(drel), .hold(dhold)
   );

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Level accepted after DEB consecutive synchronised disagreeing samples; hold by elapsed time since press.
   task automatic model_step();
      logic s;
      bit   flipped;
      int   d;
      cyc++;
      m_press = '0;
      m_rel   = '0;
      m_hold  = '0;
      if (rst) begin
         m_s1 = IDLE;
         m_s2 = IDLE;
         m_out = IDLE;
         for (int c = 0; c < 2; c++) begin
            m_run[c]  = 0;
            m_pcyc[c] = -1;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            flipped  = 1'b0;
            s        = m_s2[c];
            m_s2[c]  = m_s1[c];
            m_s1[c]  = din[c];
            if (s != m_out[c]) begin
               m_run[c]++;
               if (m_run[c] == DEB) begin
                  m_out[c] = s;
                  m_run[c] = 0;
                  flipped  = 1'b1;
                  if (s != IDLE[c]) begin
                     m_press[c] = 1'b1;
                     m_pcyc[c]  = cyc;
                  end else begin
                     m_rel[c]  = 1'b1;
                     m_pcyc[c] = -1;
                  end
               end
            end else begin
               m_run[c] = 0;
            end
            if (!flipped && m_pcyc[c] >= 0) begin
               d = cyc - m_pcyc[c];
               if (d == HLD || (d > HLD && ((d - HLD) % REP) == 0)) m_hold[c] = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("out", dout, m_out);
      check("active", dact, m_out ^ IDLE);
      check("press", dpress, m_press);
      check("release", drel, m_rel);
      check("hold", dhold, m_hold);
      for (int c = 0; c < 2; c++) begin
         press_seen[c] += int'(dpress[c]);
         rel_seen[c]   += int'(drel[c]);
         hold_seen[c]  += int'(dhold[c]);
      end
   endtask

   task automatic wait_press(input int ch, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (dpress[ch] !== 1'b1 && n < 40);
   endtask

   initial begin
      int n, p0, h0, r0;
      rst = 1'b1;
      din = IDLE;
      repeat (3) tick();
      rst = 1'b0;
      repeat (3) tick();

      // single-channel press latency, then long hold with repeats
      din[0] = 1'b0;
      wait_press(0, n);
      check_int("press_latency", n, 6);
      check_int("ch1_no_press", press_seen[1], 0);
      h0 = hold_seen[0];
      repeat (22) tick();
      check_int("hold_pulses_22", hold_seen[0] - h0, 3);
      r0 = rel_seen[0];
      din[0] = 1'b1;
      repeat (10) tick();
      check_int("release_once", rel_seen[0] - r0, 1);
      h0 = hold_seen[0];
      repeat (20) tick();
      check_int("no_hold_after_release", hold_seen[0] - h0, 0);

      // bouncing input: no change until it settles
      p0 = press_seen[0];
      for (int i = 0; i < 10; i++) begin
         din[0] = (i % 2 == 1);
         repeat (2) tick();
      end
      check_int("toggle_no_press", press_seen[0] - p0, 0);
      din[0] = 1'b0;
      wait_press(0, n);
      check_int("settle_latency", n, 6);
      din[0] = 1'b1;
      repeat (20) tick();

      // early release cancels hold; re-press restarts hold timing
      din[0] = 1'b0;
      wait_press(0, n);
      repeat (2) tick();
      din[0] = 1'b1;
      h0 = hold_seen[0];
      r0 = rel_seen[0];
      repeat (15) tick();
      check_int("early_release_no_hold", hold_seen[0] - h0, 0);
      check_int("early_release_once", rel_seen[0] - r0, 1);
      din[0] = 1'b0;
      wait_press(0, n);
      h0 = hold_seen[0];
      repeat (10) tick();
      check_int("repress_hold_at_10", hold_seen[0] - h0, 1);
      din[0] = 1'b1;
      repeat (15) tick();

      // reset mid-debounce aborts, count restarts after reset
      din[0] = 1'b0;
      repeat (4) tick();
      p0 = press_seen[0];
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_press(0, n);
      check_int("post_reset_latency", n, 6);
      check_int("post_reset_single_press", press_seen[0] - p0, 1);
      din[0] = 1'b1;
      repeat (15) tick();

      // simultaneous change on both channels
      din = 2'b00;
      wait_press(0, n);
      check_int("both_latency", n, 6);
      check_int("both_press_ch1", int'(dpress[1]), 1);
      din = IDLE;
      repeat (15) tick();

      // randomized traffic with occasional reset
      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) din = 2'($urandom);
         rst = ($urandom_range(0, 249) == 0);
         tick();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
